// File: rtl/comp_pkg.sv
// Shared definitions for the layer compositor: game-state encodings and default colour keys.
package comp_pkg;

  localparam logic [1:0] ST_PLAY = 2'b00;
  localparam logic [1:0] ST_WIN  = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  typedef enum logic [1:0] {
    S_PLAY = ST_PLAY,
    S_WIN  = ST_WIN,
    S_OVER = ST_OVER
  } game_state_e;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;

endpackage

// File: rtl/comp_state_fsm.sv
// Game-state FSM: PLAY/WIN/OVER with sticky pending events applied on frame_tick.
// With COMP_BLINK_EN defined, also runs the banner blink frame counter.
module comp_state_fsm
  import comp_pkg::*;
`ifdef COMP_BLINK_EN
#(
  parameter int BLINK_FRAMES = 30
)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       win_flag,
  input  logic       over_flag,
  input  logic       restart,
  output logic [1:0] game_state,
  output logic       blink_phase
);

  game_state_e state_q, state_n;
  logic        pend_win_q, pend_win_n;
  logic        pend_over_q, pend_over_n;

`ifdef COMP_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             phase_q, phase_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_PLAY;
      pend_win_q  <= 1'b0;
      pend_over_q <= 1'b0;
`ifdef COMP_BLINK_EN
      cnt_q       <= '0;
      phase_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_n;
      pend_win_q  <= pend_win_n;
      pend_over_q <= pend_over_n;
`ifdef COMP_BLINK_EN
      cnt_q       <= cnt_n;
      phase_q     <= phase_n;
`endif
    end
  end

  always_comb begin
    state_n     = state_q;
    pend_win_n  = pend_win_q;
    pend_over_n = pend_over_q;
    if (restart) begin
      state_n     = S_PLAY;
      pend_win_n  = 1'b0;
      pend_over_n = 1'b0;
    end else if (frame_tick) begin
      // A flag arriving on the tick cycle itself still counts for this frame.
      if (state_q == S_PLAY) begin
        if (pend_over_q || over_flag)    state_n = S_OVER;
        else if (pend_win_q || win_flag) state_n = S_WIN;
      end
      pend_win_n  = 1'b0;
      pend_over_n = 1'b0;
    end else if (state_q == S_PLAY) begin
      pend_win_n  = pend_win_q  | win_flag;
      pend_over_n = pend_over_q | over_flag;
    end
  end

`ifdef COMP_BLINK_EN
  always_comb begin
    cnt_n   = cnt_q;
    phase_n = phase_q;
    if (state_n == S_PLAY) begin
      cnt_n   = '0;
      phase_n = 1'b1;
    end else if (frame_tick && state_q != S_PLAY) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_n   = '0;
        phase_n = ~phase_q;
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end
  end

  assign blink_phase = phase_q;
`else
  assign blink_phase = 1'b1;
`endif

  assign game_state = state_q;

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor with game-state banner overlay, 2-cycle latency, full throughput.
// Optional banner blinking is enabled by defining COMP_BLINK_EN.
module layer_compositor
  import comp_pkg::*;
#(
  parameter int                 NUM_LAYERS   = 4,
  parameter int                 COLOR_W      = 12,
  parameter logic [COLOR_W-1:0] TRANSP0      = COLOR_W'(BLACK),
  parameter logic [COLOR_W-1:0] TRANSP1      = COLOR_W'(WHITE),
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          video_on,
  input  logic                          frame_tick,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layers_in,
  input  logic [COLOR_W-1:0]            bg_in,
  input  logic [COLOR_W-1:0]            win_in,
  input  logic [COLOR_W-1:0]            over_in,
  input  logic                          win_flag,
  input  logic                          over_flag,
  input  logic                          restart,
  output logic [COLOR_W-1:0]            vga_out,
  output logic [1:0]                    game_state
);

  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("BLINK_FRAMES must be at least 1");
  end

  logic [COLOR_W-1:0]    layer_p1 [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] opaque_p1;
  logic [COLOR_W-1:0]    bg_p1, win_p1, over_p1;
  logic                  vid_p1;
  logic [COLOR_W-1:0]    sprite_px;
  logic [COLOR_W-1:0]    pix_p2;
  logic                  blink_phase;

  function automatic logic is_opaque(input logic [COLOR_W-1:0] px);
    return (px != TRANSP0) && (px != TRANSP1);
  endfunction

`ifdef COMP_BLINK_EN
  comp_state_fsm #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_fsm (
`else
  comp_state_fsm u_fsm (
`endif
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .win_flag    (win_flag),
    .over_flag   (over_flag),
    .restart     (restart),
    .game_state  (game_state),
    .blink_phase (blink_phase)
  );

  // Stage 1: register pixel inputs and per-layer opacity
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_LAYERS; k++) layer_p1[k] <= '0;
      opaque_p1 <= '0;
      bg_p1     <= '0;
      win_p1    <= '0;
      over_p1   <= '0;
      vid_p1    <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        layer_p1[k]  <= layers_in[k*COLOR_W +: COLOR_W];
        opaque_p1[k] <= is_opaque(layers_in[k*COLOR_W +: COLOR_W]);
      end
      bg_p1   <= bg_in;
      win_p1  <= win_in;
      over_p1 <= over_in;
      vid_p1  <= video_on;
    end
  end

  // Priority scan from the lowest-priority layer up, so layer 0 is assigned last and wins.
  always_comb begin
    sprite_px = bg_p1;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (opaque_p1[k]) sprite_px = layer_p1[k];
    end
  end

  // Stage 2: select between blanking, banners and composited sprites
  always_comb begin
    pix_p2 = sprite_px;
    if (!vid_p1)                   pix_p2 = '0;
    else if (game_state == ST_OVER) pix_p2 = blink_phase ? over_p1 : bg_p1;
    else if (game_state == ST_WIN)  pix_p2 = blink_phase ? win_p1 : bg_p1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vga_out <= '0;
    else       vga_out <= pix_p2;
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus randomized traffic
// checked against a frame-level behavioural model (honours COMP_BLINK_EN).
module tb_layer_compositor;

`ifdef COMP_BLINK_EN
  localparam int BLINK_N = 2;
`else
  localparam int BLINK_N = 30;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0;
  logic        frame_tick = 1'b0;
  logic [11:0] lay [4];
  logic [47:0] layers_in;
  logic [11:0] bg_in = '0, win_in = '0, over_in = '0;
  logic        win_flag = 1'b0, over_flag = 1'b0, restart = 1'b0;
  logic [11:0] vga_out;
  logic [1:0]  game_state;

  int n_tests = 0;
  int n_fail  = 0;

  assign layers_in = {lay[3], lay[2], lay[1], lay[0]};

  layer_compositor #(
    .NUM_LAYERS   (4),
    .COLOR_W      (12),
    .TRANSP0      (12'h000),
    .TRANSP1      (12'hFFF),
    .BLINK_FRAMES (BLINK_N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .layers_in  (layers_in),
    .bg_in      (bg_in),
    .win_in     (win_in),
    .over_in    (over_in),
    .win_flag   (win_flag),
    .over_flag  (over_flag),
    .restart    (restart),
    .vga_out    (vga_out),
    .game_state (game_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          m_state;        // 0 play, 1 win, 2 over
  bit          m_pw, m_po;
  int          m_frames;       // frame ticks seen in the current banner state
  bit          m_phase;
  logic [11:0] exp_vga;
  bit          p_vid;
  logic [11:0] p_lay [4];
  logic [11:0] p_bg, p_win, p_over;

  function automatic logic [11:0] model_pixel();
    logic [11:0] banner;
    if (!p_vid) return 12'h000;
    if (m_state != 0) begin
      banner = (m_state == 2) ? p_over : p_win;
      return m_phase ? banner : p_bg;
    end
    for (int k = 0; k < 4; k++)
      if (p_lay[k] != 12'h000 && p_lay[k] != 12'hFFF) return p_lay[k];
    return p_bg;
  endfunction

  task automatic model_reset();
    m_state = 0; m_pw = 0; m_po = 0; m_frames = 0; m_phase = 1;
    exp_vga = 12'h000; p_vid = 0; p_bg = 0; p_win = 0; p_over = 0;
    for (int k = 0; k < 4; k++) p_lay[k] = 0;
  endtask

  task automatic model_clock();
    int old_state;
    exp_vga = model_pixel();
    p_vid = video_on; p_bg = bg_in; p_win = win_in; p_over = over_in;
    for (int k = 0; k < 4; k++) p_lay[k] = lay[k];
    old_state = m_state;
    if (restart) begin
      m_state = 0; m_pw = 0; m_po = 0;
    end else if (frame_tick) begin
      if (m_state == 0) begin
        if (m_po || over_flag)     m_state = 2;
        else if (m_pw || win_flag) m_state = 1;
      end
      m_pw = 0; m_po = 0;
    end else if (m_state == 0) begin
      m_pw = m_pw | win_flag;
      m_po = m_po | over_flag;
    end
`ifdef COMP_BLINK_EN
    // Phase is 1 for the first BLINK_N ticks in a banner state, 0 for the next BLINK_N, ...
    if (m_state == 0) m_frames = 0;
    else if (frame_tick && old_state != 0) m_frames++;
    m_phase = ((m_frames / BLINK_N) % 2) == 0;
`else
    if (old_state < 0) m_frames = 0;
    m_phase = 1;
`endif
  endtask

  // One pixel clock: model follows the DUT edge, outputs are then sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_clock();
    @(negedge clk);
  endtask

  function automatic logic [11:0] rnd_px();
    case ($urandom_range(0, 3))
      0:       return 12'h000;
      1:       return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic idle_inputs();
    frame_tick = 0; win_flag = 0; over_flag = 0; restart = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    for (int k = 0; k < 4; k++) lay[k] = 12'h5A5;
    repeat (2) @(negedge clk);
    n_tests++;
    if (vga_out !== 12'h000) begin
      n_fail++; $display("FAIL reset_vga: got %h want 000", vga_out);
    end
    n_tests++;
    if (game_state !== 2'b00) begin
      n_fail++; $display("FAIL reset_state: got %b want 00", game_state);
    end
    reset = 0;
  endtask

  task automatic test_priority();
    lay[0] = 12'h000; lay[1] = 12'hF00; lay[2] = 12'h0F0; lay[3] = 12'h00F;
    bg_in = 12'h321; video_on = 1;
    step();
    n_tests++;
    if (vga_out !== exp_vga) begin
      n_fail++; $display("FAIL priority_lat1: got %h want %h", vga_out, exp_vga);
    end
    step();
    n_tests++;
    if (vga_out !== 12'hF00) begin
      n_fail++; $display("FAIL priority_lat2: got %h want F00", vga_out);
    end
  endtask

  task automatic test_transparency();
    for (int k = 0; k < 4; k++) lay[k] = $urandom_range(0, 1) ? 12'hFFF : 12'h000;
    bg_in = 12'h123; video_on = 1;
    repeat (2) step();
    n_tests++;
    if (vga_out !== 12'h123) begin
      n_fail++; $display("FAIL transp_bg: got %h want 123", vga_out);
    end
    video_on = 0;
    repeat (2) step();
    n_tests++;
    if (vga_out !== 12'h000) begin
      n_fail++; $display("FAIL blank: got %h want 000", vga_out);
    end
  endtask

  task automatic test_random_pixels();
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 4; k++) lay[k] = rnd_px();
      bg_in = 12'($urandom); video_on = ($urandom_range(0, 7) != 0);
      step();
      n_tests++;
      if (vga_out !== exp_vga) begin
        n_fail++; $display("FAIL rnd_pix cyc %0d: got %h want %h", i, vga_out, exp_vga);
      end
    end
  endtask

  task automatic test_events();
    lay[0] = 12'h0AA; lay[1] = 12'h000; lay[2] = 12'h000; lay[3] = 12'h000;
    over_in = 12'hE0E; win_in = 12'h0E0; video_on = 1;
    over_flag = 1; win_flag = 1;
    step();
    over_flag = 0; win_flag = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (game_state !== 2'b00) begin
        n_fail++; $display("FAIL ev_hold cyc %0d: got %b want 00", i, game_state);
      end
    end
    frame_tick = 1;
    step();
    frame_tick = 0;
    n_tests++;
    if (game_state !== 2'b10) begin
      n_fail++; $display("FAIL ev_over: got %b want 10", game_state);
    end
    step();
    n_tests++;
    if (vga_out !== 12'hE0E) begin
      n_fail++; $display("FAIL ev_over_px: got %h want E0E", vga_out);
    end
    win_flag = 1;
    step();
    win_flag = 0; frame_tick = 1;
    step();
    frame_tick = 0;
    step();
    n_tests++;
    if (game_state !== 2'b10) begin
      n_fail++; $display("FAIL ev_late_win: got %b want 10", game_state);
    end
  endtask

  task automatic test_restart_race();
    lay[0] = 12'hABC;
    restart = 1; frame_tick = 1;
    step();
    restart = 0; frame_tick = 0;
    n_tests++;
    if (game_state !== 2'b00) begin
      n_fail++; $display("FAIL restart_state: got %b want 00", game_state);
    end
    step();
    n_tests++;
    if (vga_out !== 12'hABC) begin
      n_fail++; $display("FAIL restart_px: got %h want ABC", vga_out);
    end
  endtask

  task automatic test_async_reset();
    win_flag = 1;
    step();
    win_flag = 0; frame_tick = 1;
    step();
    frame_tick = 0;
    step();
    n_tests++;
    if (game_state !== 2'b01 || vga_out !== win_in) begin
      n_fail++; $display("FAIL pre_reset_win: got %b/%h want 01/%h", game_state, vga_out, win_in);
    end
    #2 reset = 1;
    #1;
    n_tests++;
    if (vga_out !== 12'h000 || game_state !== 2'b00) begin
      n_fail++; $display("FAIL async_reset: got %h/%b want 000/00", vga_out, game_state);
    end
    step();
    reset = 0;
  endtask

  task automatic test_random_fsm();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      for (int k = 0; k < 4; k++) lay[k] = rnd_px();
      bg_in = 12'($urandom); win_in = 12'($urandom); over_in = 12'($urandom);
      video_on = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) frame_tick = 1;
      else begin
        win_flag  = ($urandom_range(0, 30) == 0);
        over_flag = ($urandom_range(0, 40) == 0);
      end
      restart = ($urandom_range(0, 60) == 0);
      step();
      n_tests++;
      if (vga_out !== exp_vga || game_state !== 2'(m_state)) begin
        n_fail++;
        $display("FAIL rnd_fsm cyc %0d: got %h/%b want %h/%0d", i, vga_out, game_state, exp_vga, m_state);
      end
    end
    idle_inputs();
  endtask

  task automatic test_blink();
    restart = 1;
    step();
    restart = 0;
    for (int k = 0; k < 4; k++) lay[k] = 12'h456;
    bg_in = 12'h111; win_in = 12'h9C9; video_on = 1;
    win_flag = 1;
    step();
    win_flag = 0; frame_tick = 1;
    step();
    frame_tick = 0;
    step();
    for (int t = 0; t < 6; t++) begin
      frame_tick = 1;
      step();
      frame_tick = 0;
      for (int c = 0; c < 4; c++) begin
        step();
        n_tests++;
        if (vga_out !== exp_vga) begin
          n_fail++; $display("FAIL blink t%0d c%0d: got %h want %h", t, c, vga_out, exp_vga);
        end
`ifndef COMP_BLINK_EN
        n_tests++;
        if (vga_out !== 12'h9C9) begin
          n_fail++; $display("FAIL steady_banner t%0d: got %h want 9C9", t, vga_out);
        end
`endif
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) lay[k] = 12'h000;
    test_reset();
    test_priority();
    test_transparency();
    test_random_pixels();
    test_events();
    test_restart_race();
    test_async_reset();
    test_random_fsm();
    test_blink();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
